// File: rtl/ap_ctrl_pkg.sv
// Shared types and defaults for the ap_ctrl_chain handshake sequencer.
package ap_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over increment.
module sat_counter
  import ap_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ap_ctrl_chain_sequencer.sv
// Drives an HLS kernel's ap_ctrl_chain handshake for a programmed number of
// transactions, keeping a bounded number in flight and releasing results via ap_continue.
module ap_ctrl_chain_sequencer
  import ap_ctrl_pkg::*;
#(
  parameter  int unsigned CNT_W           = CNT_W_DEF,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] num_trans,
  input  logic             cont_en,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic [OUT_W-1:0] outstanding,
  output logic [CNT_W-1:0] started_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy,
  output logic             finish,
  output logic             proto_err
);

  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             start_q, start_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;

  logic active, run_acc, accept, complete, good_complete;

  assign active        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign run_acc       = run && !active;
  assign accept        = start_q && ap_ready;
  assign complete      = ap_done && ap_continue;
  // A completion with nothing in flight is a kernel fault; it flags but never counts.
  assign good_complete = complete && (out_q != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      started_q <= '0;
      done_q    <= '0;
      out_q     <= '0;
      start_q   <= 1'b0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      started_q <= started_d;
      done_q    <= done_d;
      out_q     <= out_d;
      start_q   <= start_d;
      finish_q  <= finish_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    started_d = started_q + CNT_W'(accept);
    done_d    = done_q + CNT_W'(good_complete);
    out_d     = out_q + OUT_W'(accept) - OUT_W'(good_complete);
    err_d     = err_q || (complete && (out_q == '0)) || (ap_done && (state_q == S_IDLE));
    finish_d  = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH: begin
        finish_d = (state_q == S_FINISH) && !run;
        if (run) begin
          num_d     = num_trans;
          started_d = '0;
          done_d    = '0;
          state_d   = (num_trans == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (started_d == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (done_q == num_q) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase

    // Look-ahead on next counts: a same-cycle completion keeps a full pipe issuing.
    start_d = (state_d == S_ISSUE) && (started_d < num_d) && (out_d < MAX_OUT);
  end

  always_comb begin
    ap_continue = ap_done && cont_en && active;
    busy        = active;
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (run_acc),
    .inc   (active),
    .q     (cycle_cnt)
  );

  assign ap_start    = start_q;
  assign outstanding = out_q;
  assign started_cnt = started_q;
  assign done_cnt    = done_q;
  assign finish      = finish_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_ap_ctrl_chain_sequencer.sv
// Directed bench for ap_ctrl_chain_sequencer: one instance with 4 outstanding, one with 1.
module tb_ap_ctrl_chain_sequencer;

  localparam int CNT_W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic             a_run, a_cont_en, a_ap_ready, a_ap_done;
  logic [CNT_W-1:0] a_num;
  logic             a_ap_start, a_ap_continue, a_busy, a_finish, a_proto_err;
  logic [2:0]       a_out;
  logic [CNT_W-1:0] a_started, a_done_cnt, a_cycle;

  logic             b_run, b_cont_en, b_ap_ready, b_ap_done;
  logic [CNT_W-1:0] b_num;
  logic             b_ap_start, b_ap_continue, b_busy, b_finish, b_proto_err;
  logic [0:0]       b_out;
  logic [CNT_W-1:0] b_started, b_done_cnt, b_cycle;

  int vectors;
  int miscompares;

  ap_ctrl_chain_sequencer #(.CNT_W(CNT_W), .MAX_OUTSTANDING(4)) u_dut_a (
    .clock(clock), .reset(reset), .run(a_run), .num_trans(a_num), .cont_en(a_cont_en),
    .ap_start(a_ap_start), .ap_ready(a_ap_ready), .ap_done(a_ap_done),
    .ap_continue(a_ap_continue), .outstanding(a_out), .started_cnt(a_started),
    .done_cnt(a_done_cnt), .cycle_cnt(a_cycle), .busy(a_busy), .finish(a_finish),
    .proto_err(a_proto_err)
  );

  ap_ctrl_chain_sequencer #(.CNT_W(CNT_W), .MAX_OUTSTANDING(1)) u_dut_b (
    .clock(clock), .reset(reset), .run(b_run), .num_trans(b_num), .cont_en(b_cont_en),
    .ap_start(b_ap_start), .ap_ready(b_ap_ready), .ap_done(b_ap_done),
    .ap_continue(b_ap_continue), .outstanding(b_out), .started_cnt(b_started),
    .done_cnt(b_done_cnt), .cycle_cnt(b_cycle), .busy(b_busy), .finish(b_finish),
    .proto_err(b_proto_err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    a_run = 1'b0; a_num = '0; a_cont_en = 1'b0; a_ap_ready = 1'b0; a_ap_done = 1'b0;
    b_run = 1'b0; b_num = '0; b_cont_en = 1'b0; b_ap_ready = 1'b0; b_ap_done = 1'b0;
    tick;
    tick;
    reset = 1'b0;

    check("rst_start",   64'(a_ap_start),  0);
    check("rst_out",     64'(a_out),       0);
    check("rst_finish",  64'(a_finish),    0);
    check("rst_err",     64'(a_proto_err), 0);
    check("rst_busy",    64'(a_busy),      0);
    check("rst_started", 64'(a_started),   0);
    check("rst_cycle",   64'(a_cycle),     0);

    // Three back-to-back starts, each result two cycles later.
    a_num = 3; a_run = 1'b1; a_cont_en = 1'b1; a_ap_ready = 1'b1;
    tick;
    a_run = 1'b0;
    check("t1_start_rise", 64'(a_ap_start), 1);
    check("t1_busy",       64'(a_busy),     1);
    tick;
    check("t1_started1", 64'(a_started),  1);
    check("t1_out1",     64'(a_out),      1);
    check("t1_start_hi", 64'(a_ap_start), 1);
    tick;
    check("t1_started2", 64'(a_started), 2);
    check("t1_out2",     64'(a_out),     2);
    a_ap_done = 1'b1;
    settle;
    check("t1_cont", 64'(a_ap_continue), 1);
    tick;
    a_ap_ready = 1'b0;
    check("t1_started3", 64'(a_started),  3);
    check("t1_start_lo", 64'(a_ap_start), 0);
    check("t1_out_peak", 64'(a_out),      2);
    check("t1_done1",    64'(a_done_cnt), 1);
    tick;
    check("t1_done2", 64'(a_done_cnt), 2);
    check("t1_out_1", 64'(a_out),      1);
    tick;
    a_ap_done = 1'b0;
    check("t1_done3", 64'(a_done_cnt), 3);
    check("t1_out_0", 64'(a_out),      0);
    tick;
    check("t1_busy_lo",   64'(a_busy),   0);
    check("t1_finish_lag", 64'(a_finish), 0);
    tick;
    check("t1_finish", 64'(a_finish),   1);
    check("t1_cycles", 64'(a_cycle),    6);
    check("t1_done_f", 64'(a_done_cnt), 3);

    // Zero-length run straight from FINISH.
    a_num = 0; a_run = 1'b1;
    tick;
    a_run = 1'b0;
    check("t4_finish_clr", 64'(a_finish),   0);
    check("t4_started",    64'(a_started),  0);
    check("t4_done",       64'(a_done_cnt), 0);
    tick;
    check("t4_finish", 64'(a_finish),   1);
    check("t4_start",  64'(a_ap_start), 0);
    check("t4_cycle",  64'(a_cycle),    0);

    // Backpressure: results held for ten cycles, then drained one per cycle.
    a_num = 2; a_run = 1'b1; a_ap_ready = 1'b1; a_cont_en = 1'b0;
    tick;
    a_run = 1'b0;
    check("t3_start", 64'(a_ap_start), 1);
    tick;
    tick;
    a_ap_ready = 1'b0;
    a_ap_done  = 1'b1;
    settle;
    check("t3_started", 64'(a_started),     2);
    check("t3_out2",    64'(a_out),         2);
    check("t3_cont_lo", 64'(a_ap_continue), 0);
    for (int i = 0; i < 10; i++) tick;
    check("t3_done_frozen", 64'(a_done_cnt),    0);
    check("t3_out_frozen",  64'(a_out),         2);
    check("t3_cont_held",   64'(a_ap_continue), 0);
    a_cont_en = 1'b1;
    settle;
    check("t3_cont_hi", 64'(a_ap_continue), 1);
    tick;
    check("t3_done1", 64'(a_done_cnt), 1);
    tick;
    a_ap_done = 1'b0;
    check("t3_done2", 64'(a_done_cnt), 2);
    check("t3_out0",  64'(a_out),      0);
    tick;
    tick;
    check("t3_finish", 64'(a_finish), 1);

    // Spurious done with nothing in flight, then a run pulse during DRAIN.
    a_num = 2; a_run = 1'b1; a_ap_ready = 1'b0;
    tick;
    a_run = 1'b0;
    a_ap_done = 1'b1;
    tick;
    a_ap_done = 1'b0;
    check("t5_err",        64'(a_proto_err), 1);
    check("t5_done_keep",  64'(a_done_cnt),  0);
    check("t5_out_keep",   64'(a_out),       0);
    check("t5_start_hold", 64'(a_ap_start),  1);
    a_ap_ready = 1'b1;
    tick;
    tick;
    a_ap_ready = 1'b0;
    check("t5_started", 64'(a_started), 2);
    a_num = 7; a_run = 1'b1;
    tick;
    a_run = 1'b0;
    check("t5_run_ign",   64'(a_started),   2);
    check("t5_busy",      64'(a_busy),      1);
    check("t5_err_stick", 64'(a_proto_err), 1);
    a_ap_done = 1'b1;
    tick;
    tick;
    a_ap_done = 1'b0;
    check("t5_done2", 64'(a_done_cnt), 2);
    tick;
    tick;
    check("t5_finish", 64'(a_finish),    1);
    check("t5_err_f",  64'(a_proto_err), 1);

    // Reset mid-ISSUE with two transactions in flight.
    a_num = 5; a_run = 1'b1; a_ap_ready = 1'b1;
    tick;
    a_run = 1'b0;
    tick;
    tick;
    check("t6_out_pre",   64'(a_out),      2);
    check("t6_start_pre", 64'(a_ap_start), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t6_start",   64'(a_ap_start),  0);
    check("t6_out",     64'(a_out),       0);
    check("t6_busy",    64'(a_busy),      0);
    check("t6_finish",  64'(a_finish),    0);
    check("t6_err",     64'(a_proto_err), 0);
    check("t6_started", 64'(a_started),   0);
    tick;
    a_ap_ready = 1'b0;
    check("t6_ready_ign", 64'(a_started), 0);
    check("t6_out_ign",   64'(a_out),     0);
    a_ap_done = 1'b1;
    settle;
    check("t6_cont_idle", 64'(a_ap_continue), 0);
    tick;
    a_ap_done = 1'b0;
    check("t6_err_idle",  64'(a_proto_err), 1);
    check("t6_done_idle", 64'(a_done_cnt),  0);

    // Single-slot instance: second start waits for the first completion.
    b_num = 2; b_run = 1'b1; b_ap_ready = 1'b1; b_cont_en = 1'b1;
    tick;
    b_run = 1'b0;
    check("t2_start1", 64'(b_ap_start), 1);
    check("t2_out0",   64'(b_out),      0);
    tick;
    check("t2_full_lo", 64'(b_ap_start), 0);
    check("t2_out1",    64'(b_out),      1);
    check("t2_started", 64'(b_started),  1);
    tick;
    check("t2_wait_lo",  64'(b_ap_start), 0);
    check("t2_wait_out", 64'(b_out),      1);
    b_ap_done = 1'b1;
    tick;
    b_ap_done = 1'b0;
    check("t2_start2", 64'(b_ap_start), 1);
    check("t2_out_c",  64'(b_out),      0);
    check("t2_done1",  64'(b_done_cnt), 1);
    tick;
    check("t2_started2", 64'(b_started),  2);
    check("t2_start_lo", 64'(b_ap_start), 0);
    check("t2_out_1b",   64'(b_out),      1);
    b_ap_done = 1'b1;
    tick;
    b_ap_done = 1'b0;
    check("t2_done2", 64'(b_done_cnt), 2);
    check("t2_out_z", 64'(b_out),      0);
    tick;
    tick;
    check("t2_finish", 64'(b_finish),    1);
    check("t2_err",    64'(b_proto_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
